// File: rtl/mmu_req_merge_sink.sv
// rtl/mmu_req_merge_sink.sv - clocked sink for the async MMU request merge: toggle sync, FIFO, valid/ready out
module mmu_req_merge_sink #(
    parameter int DATA_WIDTH  = 88,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_drive,
    input  logic [DATA_WIDTH-1:0]        i_data,
    output logic                         o_free,
    output logic                         o_valid,
    output logic [DATA_WIDTH-1:0]        o_data,
    input  logic                         i_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic [15:0]                  o_stall_cnt
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = $clog2(DEPTH+1);
    localparam logic [LEVEL_W-1:0] DEPTH_L = LEVEL_W'(DEPTH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   phase;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LEVEL_W-1:0]     level;
    logic [15:0]            stall_cnt;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic drv_s;
    logic pending;
    logic full;
    logic accept;
    logic pop;

    // A request is outstanding while the synchronised toggle disagrees with our ack phase.
    assign drv_s   = sync_q[SYNC_STAGES-1];
    assign pending = drv_s ^ phase;
    assign full    = (level == DEPTH_L);
    assign accept  = pending && !full;
    assign pop     = o_valid && i_ready;

    assign o_free      = phase;
    assign o_valid     = (level != '0);
    assign o_data      = mem[rd_ptr];
    assign o_level     = level;
    assign o_stall_cnt = stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            phase     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            stall_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_drive};

            if (accept) begin
                mem[wr_ptr] <= i_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
                phase       <= ~phase;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({accept, pop})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase

            // Full-FIFO wait uses the pre-pop level, so a same-cycle pop still counts as a stall.
            if (pending && full && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mmu_req_merge_sink.sv
// tb/tb_mmu_req_merge_sink.sv - directed table-driven bench for mmu_req_merge_sink
module tb_mmu_req_merge_sink;

    logic        clk;
    logic        rst;
    logic        i_drive;
    logic [87:0] i_data;
    logic        o_free;
    logic        o_valid;
    logic [87:0] o_data;
    logic        i_ready;
    logic [2:0]  o_level;
    logic [15:0] o_stall_cnt;

    int errors = 0;
    int checks = 0;

    mmu_req_merge_sink #(
        .DATA_WIDTH (88),
        .DEPTH      (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_drive    (i_drive),
        .i_data     (i_data),
        .o_free     (o_free),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .i_ready    (i_ready),
        .o_level    (o_level),
        .o_stall_cnt(o_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [87:0] data;
        bit          exp_ack;
        logic [2:0]  exp_level;
    } vec_t;

    task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int budget, output int n);
        n = 0;
        while (o_free !== i_drive && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_free"},  88'(o_free),      88'd0);
        check({name, "_valid"}, 88'(o_valid),     88'd0);
        check({name, "_level"}, 88'(o_level),     88'd0);
        check({name, "_stall"}, 88'(o_stall_cnt), 88'd0);
    endtask

    vec_t vecs[5];

    initial begin
        int n;
        int s0;
        int sent;
        int got;
        int max_level;

        vecs[0] = '{88'd1, 1'b1, 3'd1};
        vecs[1] = '{88'd2, 1'b1, 3'd2};
        vecs[2] = '{88'd3, 1'b1, 3'd3};
        vecs[3] = '{88'd4, 1'b1, 3'd4};
        vecs[4] = '{88'd5, 1'b0, 3'd4};

        rst     = 1'b1;
        i_drive = 1'b0;
        i_data  = '0;
        i_ready = 1'b0;
        repeat (3) tick();
        check_idle("reset_hold");
        rst = 1'b0;
        tick();
        check_idle("reset_rel");
        check("reset_data", o_data, 88'd0);

        // Single request: ack must take 2..3 edges through the synchroniser.
        i_data  = 88'hA5;
        i_drive = 1'b1;
        tick();
        check("single_early", 88'(o_free), 88'd0);
        wait_ack(6, n);
        check("single_latency_ok", 88'((n + 1) >= 2 && (n + 1) <= 3), 88'd1);
        check("single_free",  88'(o_free),  88'd1);
        check("single_valid", 88'(o_valid), 88'd1);
        check("single_data",  o_data,       88'hA5);
        check("single_level", 88'(o_level), 88'd1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("single_pop_level", 88'(o_level), 88'd0);
        check("single_pop_valid", 88'(o_valid), 88'd0);

        // Fill from the vector table; the fifth request must stay unacked.
        for (int i = 0; i < 5; i++) begin
            i_data  = vecs[i].data;
            i_drive = ~i_drive;
            if (vecs[i].exp_ack) begin
                wait_ack(8, n);
                check($sformatf("fill_ack%0d", i), 88'(o_free == i_drive), 88'd1);
            end else begin
                repeat (6) tick();
                check($sformatf("fill_noack%0d", i), 88'(o_free == i_drive), 88'd0);
            end
            check($sformatf("fill_level%0d", i), 88'(o_level), 88'(vecs[i].exp_level));
        end
        check("fill_head", o_data, 88'd1);
        s0 = int'(o_stall_cnt);
        check("stall_nonzero", 88'(s0 != 0), 88'd1);
        tick();
        check("stall_inc1", 88'(o_stall_cnt), 88'(s0 + 1));
        tick();
        check("stall_inc2", 88'(o_stall_cnt), 88'(s0 + 2));

        // Drain: the pending fifth entry lands on the edge after the first pop.
        i_ready = 1'b1;
        check("drain_d1", o_data, 88'd1);
        tick();
        check("drain_l1", 88'(o_level), 88'd3);
        check("drain_noack_yet", 88'(o_free == i_drive), 88'd0);
        check("drain_d2", o_data, 88'd2);
        tick();
        check("drain_l2", 88'(o_level), 88'd3);
        check("drain_ack5", 88'(o_free == i_drive), 88'd1);
        check("drain_d3", o_data, 88'd3);
        tick();
        check("drain_l3", 88'(o_level), 88'd2);
        check("drain_d4", o_data, 88'd4);
        tick();
        check("drain_l4", 88'(o_level), 88'd1);
        check("drain_d5", o_data, 88'd5);
        tick();
        check("drain_l5", 88'(o_level), 88'd0);
        check("drain_valid", 88'(o_valid), 88'd0);
        tick();
        check("drain_underflow", 88'(o_level), 88'd0);
        i_ready = 1'b0;

        // Reset mid-burst: one entry stored, another in flight.
        i_data  = 88'h11;
        i_drive = ~i_drive;
        wait_ack(8, n);
        i_data  = 88'h22;
        i_drive = ~i_drive;
        tick();
        rst     = 1'b1;
        i_drive = 1'b0;
        #2;
        check_idle("midrst_async");
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        check_idle("midrst_after");

        // Wrap: ten requests streamed through with the consumer always ready.
        i_ready   = 1'b1;
        sent      = 0;
        got       = 0;
        max_level = 0;
        for (int c = 0; c < 300 && got < 10; c++) begin
            if (int'(o_level) > max_level) max_level = int'(o_level);
            if (o_valid) begin
                check($sformatf("wrap_order%0d", got), o_data, 88'(got));
                got++;
            end
            if (sent < 10 && o_free == i_drive) begin
                i_data  = 88'(sent);
                i_drive = ~i_drive;
                sent++;
            end
            tick();
        end
        check("wrap_count", 88'(got), 88'd10);
        check("wrap_maxlevel_le1", 88'(max_level <= 1), 88'd1);
        check("wrap_stall", 88'(o_stall_cnt), 88'd0);
        check("wrap_level_end", 88'(o_level), 88'd0);
        i_ready = 1'b0;

        // Saturation: full FIFO with a request parked for longer than 16 bits can count.
        for (int i = 0; i < 4; i++) begin
            i_data  = 88'(100 + i);
            i_drive = ~i_drive;
            wait_ack(8, n);
        end
        check("sat_full", 88'(o_level), 88'd4);
        i_data  = 88'd200;
        i_drive = ~i_drive;
        repeat (70000) @(posedge clk);
        #1;
        check("sat_value", 88'(o_stall_cnt), 88'hFFFF);
        repeat (50) tick();
        check("sat_hold", 88'(o_stall_cnt), 88'hFFFF);
        check("sat_noack", 88'(o_free == i_drive), 88'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
